// File: rtl/ysyx_220053_ifu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_220053_ifu_pkg
//  Description : Shared definitions for the instruction fetch unit: the NOP
//                encoding, the IFU state encodings, the default reset PC and
//                a small alignment helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package ysyx_220053_ifu_pkg;

   // addi x0, x0, 0 -- handed to decode whenever there is no real instruction
   localparam logic [31:0] IFU_NOP          = 32'h00000013;
   localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

   typedef enum logic [2:0] {
      IFU_BOOT  = 3'd0,
      IFU_REQ   = 3'd1,
      IFU_WAIT  = 3'd2,
      IFU_HOLD  = 3'd3,
      IFU_FLUSH = 3'd4
   } ifu_state_e;

   function automatic logic is_misaligned(input logic [1:0] pc_lo);
      return pc_lo != 2'b00;
   endfunction

endpackage : ysyx_220053_ifu_pkg
`default_nettype wire

// File: rtl/ysyx_220053_ifu_pc_reg.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_220053_pc_reg
//  Description : Fetch PC register with +4 increment (wrapping modulo
//                2^XLEN) and a pending-redirect register that remembers a
//                redirect target arriving while a request is still waiting
//                for acceptance.
//  Ports       : clk, rst_n          clock / async active-low reset
//                pc_load, pc_load_val load PC with an explicit target
//                pc_inc               advance PC by 4 (pc_load wins)
//                pend_set, pend_set_val record a pending redirect target
//                pend_clr             drop the pending redirect
//                pc, pend_valid, pend_pc  current register contents
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_220053_pc_reg
   import ysyx_220053_ifu_pkg::*;
#(
   parameter int unsigned     XLEN     = 64,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            pc_load,
   input  logic [XLEN-1:0] pc_load_val,
   input  logic            pc_inc,
   input  logic            pend_set,
   input  logic [XLEN-1:0] pend_set_val,
   input  logic            pend_clr,
   output logic [XLEN-1:0] pc,
   output logic            pend_valid,
   output logic [XLEN-1:0] pend_pc
);

   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

   logic [XLEN-1:0] pc_d, pc_q;
   logic            pend_valid_d, pend_valid_q;
   logic [XLEN-1:0] pend_pc_d, pend_pc_q;

   always_comb begin
      pc_d = pc_q;
      if (pc_load) begin
         pc_d = pc_load_val;
      end else if (pc_inc) begin
         pc_d = pc_q + PC_STEP;
      end
   end

   // A newer redirect simply overwrites an older pending target.
   always_comb begin
      pend_valid_d = pend_valid_q;
      pend_pc_d    = pend_pc_q;
      if (pend_set) begin
         pend_valid_d = 1'b1;
         pend_pc_d    = pend_set_val;
      end else if (pend_clr) begin
         pend_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q         <= RESET_PC;
         pend_valid_q <= 1'b0;
         pend_pc_q    <= '0;
      end else begin
         pc_q         <= pc_d;
         pend_valid_q <= pend_valid_d;
         pend_pc_q    <= pend_pc_d;
      end
   end

   assign pc         = pc_q;
   assign pend_valid = pend_valid_q;
   assign pend_pc    = pend_pc_q;

endmodule : ysyx_220053_pc_reg
`default_nettype wire

// File: rtl/ysyx_220053_ifu.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_220053_ifu
//  Description : Instruction fetch unit. Owns the PC, issues 32-bit fetches
//                on a valid/ready request + valid-only response port and
//                presents {instr_o, pc_o} to decode with valid/ready.
//                Accepts single-cycle redirect pulses from branches/jumps.
//  Ports       : clk, rst_n                     clock / async active-low reset
//                redirect_valid, redirect_pc    redirect pulse and target
//                imem_req_valid/ready/addr      fetch request channel
//                imem_rsp_valid/data/err        fetch response channel
//                instr_valid/ready, instr_o,
//                pc_o, fetch_err_o, misalign_o  decode-side interface
//  Config      : YSYX_220053_IFU_MISALIGN_EN - when defined, a misaligned
//                PC raises a fault instead of fetching; otherwise the
//                request address is word-aligned and misalign_o stays 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_220053_ifu
   import ysyx_220053_ifu_pkg::*;
#(
   parameter int unsigned     XLEN     = 64,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   input  logic            imem_rsp_err,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [31:0]     instr_o,
   output logic [XLEN-1:0] pc_o,
   output logic            fetch_err_o,
   output logic            misalign_o
);

   ifu_state_e      state_d, state_q;
   logic [31:0]     instr_d, instr_q;
   logic [XLEN-1:0] pc_out_d, pc_out_q;
   logic            ferr_d, ferr_q;
   logic            mis_d, mis_q;

   logic            pc_load;
   logic [XLEN-1:0] pc_load_val;
   logic            pc_inc;
   logic            pend_set;
   logic            pend_clr;
   logic [XLEN-1:0] pc;
   logic            pend_valid;
   logic [XLEN-1:0] pend_pc;
   logic            req_valid;
   logic            pc_fault;

   ysyx_220053_pc_reg #(
      .XLEN     (XLEN),
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk          (clk),
      .rst_n        (rst_n),
      .pc_load      (pc_load),
      .pc_load_val  (pc_load_val),
      .pc_inc       (pc_inc),
      .pend_set     (pend_set),
      .pend_set_val (redirect_pc),
      .pend_clr     (pend_clr),
      .pc           (pc),
      .pend_valid   (pend_valid),
      .pend_pc      (pend_pc)
   );

`ifdef YSYX_220053_IFU_MISALIGN_EN
   assign pc_fault      = is_misaligned(pc[1:0]);
   assign imem_req_addr = pc;
`else
   // Without fault checking the fetch is forced word-aligned; pc_fault is
   // constant 0 so misalign_o never rises.
   assign pc_fault      = 1'b0;
   assign imem_req_addr = {pc[XLEN-1:2], 2'b00};
`endif

   always_comb begin
      state_d     = state_q;
      instr_d     = instr_q;
      pc_out_d    = pc_out_q;
      ferr_d      = ferr_q;
      mis_d       = mis_q;
      pc_load     = 1'b0;
      pc_load_val = redirect_pc;
      pc_inc      = 1'b0;
      pend_set    = 1'b0;
      pend_clr    = 1'b0;
      req_valid   = 1'b0;

      case (state_q)
         IFU_BOOT: begin
            state_d = IFU_REQ;
            pc_load = redirect_valid;
         end

         IFU_REQ: begin
            if (pc_fault) begin
               // Faulting PC: no bus request, hand a trapping NOP to decode.
               // A redirect arriving now just retargets and re-evaluates.
               if (redirect_valid) begin
                  pc_load = 1'b1;
               end else begin
                  state_d  = IFU_HOLD;
                  instr_d  = IFU_NOP;
                  pc_out_d = pc;
                  ferr_d   = 1'b1;
                  mis_d    = 1'b1;
               end
            end else begin
               req_valid = 1'b1;
               if (imem_req_ready) begin
                  // Once the request is accepted the PC register is free to
                  // hold the redirect target while FLUSH drains the response.
                  if (redirect_valid) begin
                     pc_load  = 1'b1;
                     pend_clr = 1'b1;
                     state_d  = IFU_FLUSH;
                  end else if (pend_valid) begin
                     pc_load     = 1'b1;
                     pc_load_val = pend_pc;
                     pend_clr    = 1'b1;
                     state_d     = IFU_FLUSH;
                  end else begin
                     state_d = IFU_WAIT;
                  end
               end else if (redirect_valid) begin
                  // The address must stay stable until accepted, so the
                  // target is parked instead of loaded.
                  pend_set = 1'b1;
               end
            end
         end

         IFU_WAIT: begin
            if (redirect_valid) begin
               pc_load = 1'b1;
               state_d = imem_rsp_valid ? IFU_REQ : IFU_FLUSH;
            end else if (imem_rsp_valid) begin
               instr_d  = imem_rsp_err ? IFU_NOP : imem_rsp_data;
               pc_out_d = pc;
               ferr_d   = imem_rsp_err;
               mis_d    = 1'b0;
               state_d  = IFU_HOLD;
            end
         end

         IFU_HOLD: begin
            // Redirect has priority over consumption: no pc+4 in that case.
            if (redirect_valid) begin
               pc_load = 1'b1;
               state_d = IFU_REQ;
            end else if (instr_ready) begin
               pc_inc  = 1'b1;
               state_d = IFU_REQ;
            end
         end

         IFU_FLUSH: begin
            pc_load = redirect_valid;
            if (imem_rsp_valid) begin
               state_d = IFU_REQ;
            end
         end

         default: begin
            state_d = IFU_BOOT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IFU_BOOT;
         instr_q  <= IFU_NOP;
         pc_out_q <= RESET_PC;
         ferr_q   <= 1'b0;
         mis_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         instr_q  <= instr_d;
         pc_out_q <= pc_out_d;
         ferr_q   <= ferr_d;
         mis_q    <= mis_d;
      end
   end

   assign imem_req_valid = req_valid;
   assign instr_valid    = (state_q == IFU_HOLD);
   assign instr_o        = instr_q;
   assign pc_o           = pc_out_q;
   assign fetch_err_o    = ferr_q;
   assign misalign_o     = mis_q;

endmodule : ysyx_220053_ifu
`default_nettype wire

// File: tb/tb_ysyx_220053_ifu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ysyx_220053_ifu
//  Description : Directed self-checking bench for ysyx_220053_ifu. Inputs
//                change and outputs are sampled on the falling clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_220053_ifu;

   localparam int unsigned  XLEN = 64;
   localparam logic [63:0]  RPC  = 64'h0000_0000_8000_0000;
   localparam logic [31:0]  NOP  = 32'h00000013;

   logic            clk;
   logic            rst_n;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_rsp_valid;
   logic [31:0]     imem_rsp_data;
   logic            imem_rsp_err;
   logic            instr_valid;
   logic            instr_ready;
   logic [31:0]     instr_o;
   logic [XLEN-1:0] pc_o;
   logic            fetch_err_o;
   logic            misalign_o;

   int pass_cnt  = 0;
   int check_cnt = 0;

   ysyx_220053_ifu #(
      .XLEN     (XLEN),
      .RESET_PC (RPC)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .imem_rsp_err   (imem_rsp_err),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr_o        (instr_o),
      .pc_o           (pc_o),
      .fetch_err_o    (fetch_err_o),
      .misalign_o     (misalign_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(negedge clk);
   endtask

   // Reset held for two cycles, released on a falling edge (DUT in BOOT).
   task automatic apply_reset();
      @(negedge clk);
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      imem_rsp_err   = 1'b0;
      instr_ready    = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      tick();
      check_cnt++; if (instr_valid !== 1'b0) $display("FAIL rst_instr_valid: got %b want 0", instr_valid); else pass_cnt++;
      check_cnt++; if (instr_o !== NOP) $display("FAIL rst_instr_o: got %h want %h", instr_o, NOP); else pass_cnt++;
      check_cnt++; if (pc_o !== RPC) $display("FAIL rst_pc_o: got %h want %h", pc_o, RPC); else pass_cnt++;
      check_cnt++; if (imem_req_valid !== 1'b0) $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); else pass_cnt++;
      check_cnt++; if (imem_req_addr !== RPC) $display("FAIL rst_req_addr: got %h want %h", imem_req_addr, RPC); else pass_cnt++;
      check_cnt++; if ({fetch_err_o, misalign_o} !== 2'b00) $display("FAIL rst_err_flags: got %b want 00", {fetch_err_o, misalign_o}); else pass_cnt++;
   endtask

   task automatic test_basic_fetch();
      apply_reset();
      imem_req_ready = 1'b1;
      tick();                                   // BOOT -> REQ
      check_cnt++; if (imem_req_valid !== 1'b1) $display("FAIL t1_req_valid: got %b want 1", imem_req_valid); else pass_cnt++;
      check_cnt++; if (imem_req_addr !== 64'h80000000) $display("FAIL t1_req_addr0: got %h want 80000000", imem_req_addr); else pass_cnt++;
      tick();                                   // accepted -> WAIT
      check_cnt++; if (imem_req_valid !== 1'b0) $display("FAIL t1_wait_req: got %b want 0", imem_req_valid); else pass_cnt++;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h00100093;
      tick();                                   // -> HOLD
      imem_rsp_valid = 1'b0;
      check_cnt++; if (instr_valid !== 1'b1) $display("FAIL t1_instr_valid: got %b want 1", instr_valid); else pass_cnt++;
      check_cnt++; if (instr_o !== 32'h00100093) $display("FAIL t1_instr_o: got %h want 00100093", instr_o); else pass_cnt++;
      check_cnt++; if (pc_o !== 64'h80000000) $display("FAIL t1_pc_o: got %h want 80000000", pc_o); else pass_cnt++;
      check_cnt++; if (fetch_err_o !== 1'b0) $display("FAIL t1_fetch_err: got %b want 0", fetch_err_o); else pass_cnt++;
      instr_ready = 1'b1;
      tick();                                   // consumed -> REQ pc+4
      instr_ready = 1'b0;
      check_cnt++; if (instr_valid !== 1'b0) $display("FAIL t1_valid_drop: got %b want 0", instr_valid); else pass_cnt++;
      check_cnt++; if (imem_req_addr !== 64'h80000004) $display("FAIL t1_req_addr1: got %h want 80000004", imem_req_addr); else pass_cnt++;
   endtask

   task automatic test_hold_stall();
      tick();                                   // accepted -> WAIT
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h00200113;
      tick();                                   // -> HOLD
      imem_rsp_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check_cnt++; if (instr_valid !== 1'b1 || instr_o !== 32'h00200113 || pc_o !== 64'h80000004)
            $display("FAIL t2_hold_stable[%0d]: got v=%b i=%h pc=%h want v=1 i=00200113 pc=80000004", i, instr_valid, instr_o, pc_o);
         else pass_cnt++;
         check_cnt++; if (imem_req_valid !== 1'b0) $display("FAIL t2_no_req[%0d]: got %b want 0", i, imem_req_valid); else pass_cnt++;
         // a stray response while holding must be ignored
         imem_rsp_valid = (i == 2);
         imem_rsp_data  = 32'hDEAD0001;
         tick();
      end
      imem_rsp_valid = 1'b0;
      instr_ready    = 1'b1;
      tick();
      instr_ready = 1'b0;
      check_cnt++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h80000008)
         $display("FAIL t2_next_req: got v=%b a=%h want v=1 a=80000008", imem_req_valid, imem_req_addr);
      else pass_cnt++;
   endtask

   task automatic test_redirect_in_req();
      apply_reset();
      tick();                                   // REQ, ready low (cycle 1)
      check_cnt++; if (imem_req_addr !== 64'h80000000) $display("FAIL t3_addr_c1: got %h want 80000000", imem_req_addr); else pass_cnt++;
      tick();                                   // cycle 2
      redirect_valid = 1'b1;
      redirect_pc    = 64'h80000100;
      tick();                                   // cycle 3
      redirect_valid = 1'b0;
      check_cnt++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h80000000)
         $display("FAIL t3_addr_stable: got v=%b a=%h want v=1 a=80000000", imem_req_valid, imem_req_addr);
      else pass_cnt++;
      imem_req_ready = 1'b1;
      tick();                                   // accepted -> FLUSH
      check_cnt++; if (imem_req_valid !== 1'b0) $display("FAIL t3_flush_req: got %b want 0", imem_req_valid); else pass_cnt++;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEADBEEF;
      tick();                                   // discarded -> REQ
      imem_rsp_valid = 1'b0;
      check_cnt++; if (instr_valid !== 1'b0) $display("FAIL t3_discard: got %b want 0", instr_valid); else pass_cnt++;
      check_cnt++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h80000100)
         $display("FAIL t3_redir_addr: got v=%b a=%h want v=1 a=80000100", imem_req_valid, imem_req_addr);
      else pass_cnt++;
      tick();                                   // -> WAIT
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h00300193;
      tick();                                   // -> HOLD
      imem_rsp_valid = 1'b0;
      check_cnt++; if (instr_o !== 32'h00300193 || pc_o !== 64'h80000100)
         $display("FAIL t3_fetch: got i=%h pc=%h want i=00300193 pc=80000100", instr_o, pc_o);
      else pass_cnt++;
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
   endtask

   task automatic test_redirect_in_wait();
      tick();                                   // 0x80000104 accepted -> WAIT
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h00400213;
      redirect_valid = 1'b1;
      redirect_pc    = 64'h80000200;
      tick();                                   // response dropped -> REQ
      imem_rsp_valid = 1'b0;
      redirect_valid = 1'b0;
      check_cnt++; if (instr_valid !== 1'b0) $display("FAIL t4_no_old_instr: got %b want 0", instr_valid); else pass_cnt++;
      check_cnt++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h80000200)
         $display("FAIL t4_redir_addr: got v=%b a=%h want v=1 a=80000200", imem_req_valid, imem_req_addr);
      else pass_cnt++;
      tick();                                   // -> WAIT
      check_cnt++; if (instr_valid !== 1'b0) $display("FAIL t4_still_idle: got %b want 0", instr_valid); else pass_cnt++;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h00500293;
      tick();                                   // -> HOLD
      imem_rsp_valid = 1'b0;
      check_cnt++; if (instr_o !== 32'h00500293 || pc_o !== 64'h80000200)
         $display("FAIL t4_fetch: got i=%h pc=%h want i=00500293 pc=80000200", instr_o, pc_o);
      else pass_cnt++;
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
   endtask

   task automatic test_rsp_err();
      tick();                                   // 0x80000204 accepted -> WAIT
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h12345678;
      imem_rsp_err   = 1'b1;
      tick();                                   // -> HOLD
      imem_rsp_valid = 1'b0;
      imem_rsp_err   = 1'b0;
      check_cnt++; if (instr_valid !== 1'b1) $display("FAIL t5_valid: got %b want 1", instr_valid); else pass_cnt++;
      check_cnt++; if (instr_o !== NOP) $display("FAIL t5_instr_nop: got %h want %h", instr_o, NOP); else pass_cnt++;
      check_cnt++; if (fetch_err_o !== 1'b1) $display("FAIL t5_fetch_err: got %b want 1", fetch_err_o); else pass_cnt++;
      check_cnt++; if (pc_o !== 64'h80000204) $display("FAIL t5_pc_o: got %h want 80000204", pc_o); else pass_cnt++;
   endtask

   task automatic test_hold_redirect_and_wrap();
      // redirect beats a simultaneous consume: no pc+4
      instr_ready    = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 64'h80000300;
      tick();
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
      check_cnt++; if (instr_valid !== 1'b0) $display("FAIL t7_valid_drop: got %b want 0", instr_valid); else pass_cnt++;
      check_cnt++; if (imem_req_addr !== 64'h80000300) $display("FAIL t7_redir_hold: got %h want 80000300", imem_req_addr); else pass_cnt++;
      tick();                                   // accepted -> WAIT
      redirect_valid = 1'b1;
      redirect_pc    = 64'hFFFFFFFF_FFFFFFFC;
      tick();                                   // -> FLUSH
      redirect_valid = 1'b0;
      check_cnt++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0)
         $display("FAIL t7_flush: got req=%b v=%b want 0 0", imem_req_valid, instr_valid);
      else pass_cnt++;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hBADBAD00;
      tick();                                   // -> REQ
      imem_rsp_valid = 1'b0;
      check_cnt++; if (imem_req_addr !== 64'hFFFFFFFF_FFFFFFFC) $display("FAIL t7_top_addr: got %h want fffffffffffffffc", imem_req_addr); else pass_cnt++;
      tick();                                   // -> WAIT
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h00600313;
      tick();                                   // -> HOLD
      imem_rsp_valid = 1'b0;
      check_cnt++; if (pc_o !== 64'hFFFFFFFF_FFFFFFFC || instr_o !== 32'h00600313 || fetch_err_o !== 1'b0)
         $display("FAIL t7_top_fetch: got pc=%h i=%h e=%b want pc=fffffffffffffffc i=00600313 e=0", pc_o, instr_o, fetch_err_o);
      else pass_cnt++;
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      check_cnt++; if (imem_req_addr !== 64'h0) $display("FAIL t7_wrap: got %h want 0", imem_req_addr); else pass_cnt++;
   endtask

   task automatic test_misalign();
      apply_reset();
      redirect_valid = 1'b1;                    // redirect while in BOOT
      redirect_pc    = 64'h80000002;
      tick();                                   // -> REQ at 0x80000002
      redirect_valid = 1'b0;
`ifdef YSYX_220053_IFU_MISALIGN_EN
      check_cnt++; if (imem_req_valid !== 1'b0) $display("FAIL t6_no_req: got %b want 0", imem_req_valid); else pass_cnt++;
      tick();                                   // -> HOLD with fault
      check_cnt++; if (imem_req_valid !== 1'b0) $display("FAIL t6_no_req2: got %b want 0", imem_req_valid); else pass_cnt++;
      check_cnt++; if (instr_valid !== 1'b1 || misalign_o !== 1'b1 || fetch_err_o !== 1'b1)
         $display("FAIL t6_fault: got v=%b m=%b e=%b want 1 1 1", instr_valid, misalign_o, fetch_err_o);
      else pass_cnt++;
      check_cnt++; if (pc_o !== 64'h80000002 || instr_o !== NOP)
         $display("FAIL t6_pc_instr: got pc=%h i=%h want pc=80000002 i=%h", pc_o, instr_o, NOP);
      else pass_cnt++;
`else
      check_cnt++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h80000000)
         $display("FAIL t6_aligned_req: got v=%b a=%h want v=1 a=80000000", imem_req_valid, imem_req_addr);
      else pass_cnt++;
      imem_req_ready = 1'b1;
      tick();                                   // -> WAIT
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h00700393;
      tick();                                   // -> HOLD
      imem_rsp_valid = 1'b0;
      check_cnt++; if (misalign_o !== 1'b0 || fetch_err_o !== 1'b0 || instr_o !== 32'h00700393)
         $display("FAIL t6_no_fault: got m=%b e=%b i=%h want 0 0 00700393", misalign_o, fetch_err_o, instr_o);
      else pass_cnt++;
      check_cnt++; if (pc_o !== 64'h80000002) $display("FAIL t6_pc_o: got %h want 80000002", pc_o); else pass_cnt++;
`endif
   endtask

   initial begin
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      imem_rsp_err   = 1'b0;
      instr_ready    = 1'b0;

      test_reset();
      test_basic_fetch();
      test_hold_stall();
      test_redirect_in_req();
      test_redirect_in_wait();
      test_rsp_err();
      test_hold_redirect_and_wrap();
      test_misalign();

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule : tb_ysyx_220053_ifu
`default_nettype wire
